ccw_rcv: RTL and testbench

//  Receive end of the HSI control-command-word (CCW) link. Takes the byte stream a CCW generator emits:
//  one length byte N, then N payload bytes. Buffers the payload, presents it to the local consumer

---
 rtl/ccw_rcv_pkg.sv | 18 +
 rtl/ccw_rcv_timer.sv | 32 +++
 rtl/ccw_rcv.sv | 141 ++++++++++++++
 tb/tb_ccw_rcv.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ccw_rcv_pkg.sv
// Shared types and helpers for the CCW receive path.
// State encodings, the generator's default frame length and a saturating counter step.
package ccw_rcv_pkg;

    typedef enum logic [1:0] {
        CCWR_STATE_IDLE = 2'd0,
        CCWR_STATE_DATA = 2'd1,
        CCWR_STATE_DROP = 2'd2
    } ccwr_state_e;

    // Frame length the CCW generator emits by default.
    localparam int CCW_LEN = 4;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ccw_rcv_timer.sv
// Inter-byte gap counter: clear wins over enable.
// 'expire' flags the cycle in which the count would reach TIMEOUT.
module ccw_rcv_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + TW'(1);
        end
    end

    // A strobe in the expiring cycle clears the timer, so it also suppresses expiry.
    assign expire = en && !clr && (cnt == TW'(TIMEOUT - 1));

endmodule

// File: rtl/ccw_rcv.sv
// CCW link receiver: length byte N then N payload bytes into a local buffer,
// held for the consumer until ccw_ack; flags length, timeout and overrun errors.
module ccw_rcv
    import ccw_rcv_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] rx_d,
    input  logic       rx_d_rdy,
    output logic       ccw_rdy,
    output logic [7:0] ccw_len,
    input  logic [7:0] rd_addr,
    output logic [7:0] rd_data,
    input  logic       ccw_ack,
    output logic       rx_busy,
    output logic       err_len,
    output logic       err_timeout,
    output logic       err_overrun,
    output logic [7:0] err_cnt
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    ccwr_state_e state, state_next;
    logic [7:0]  len_r;
    logic [7:0]  idx;
    logic [7:0]  drop_cnt;
    logic [7:0]  mem [MAX_LEN];

    logic len_legal, len_bad, overrun, accept, wr_en, done, expire;

    ccw_rcv_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr    (rx_d_rdy || (state == CCWR_STATE_IDLE)),
        .en     (state != CCWR_STATE_IDLE),
        .expire (expire)
    );

    assign len_legal = (rx_d != 8'd0) && (rx_d <= 8'(MAX_LEN));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        len_bad    = 1'b0;
        overrun    = 1'b0;
        accept     = 1'b0;
        wr_en      = 1'b0;
        done       = 1'b0;
        case (state)
            CCWR_STATE_IDLE: begin
                if (rx_d_rdy) begin
                    if (!len_legal) begin
                        len_bad = 1'b1;
                    end else if (!ccw_rdy || ccw_ack) begin
                        accept     = 1'b1;
                        state_next = CCWR_STATE_DATA;
                    end else begin
                        overrun    = 1'b1;
                        state_next = CCWR_STATE_DROP;
                    end
                end
            end
            CCWR_STATE_DATA: begin
                if (rx_d_rdy) begin
                    wr_en = 1'b1;
                    if (idx == len_r - 8'd1) begin
                        done       = 1'b1;
                        state_next = CCWR_STATE_IDLE;
                    end
                end else if (expire) begin
                    state_next = CCWR_STATE_IDLE;
                end
            end
            CCWR_STATE_DROP: begin
                if (rx_d_rdy) begin
                    if (drop_cnt == 8'd1) state_next = CCWR_STATE_IDLE;
                end else if (expire) begin
                    state_next = CCWR_STATE_IDLE;
                end
            end
            default: state_next = CCWR_STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state       <= CCWR_STATE_IDLE;
            len_r       <= 8'd0;
            idx         <= 8'd0;
            drop_cnt    <= 8'd0;
            ccw_rdy     <= 1'b0;
            ccw_len     <= 8'd0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
            err_cnt     <= 8'd0;
        end else begin
            state       <= state_next;
            err_len     <= len_bad;
            err_overrun <= overrun;
            err_timeout <= expire;
            if (len_bad || overrun || expire) err_cnt <= sat_inc8(err_cnt);

            if (accept) begin
                len_r <= rx_d;
                idx   <= 8'd0;
            end else if (wr_en) begin
                idx <= idx + 8'd1;
            end

            if (overrun) begin
                drop_cnt <= rx_d;
            end else if (state == CCWR_STATE_DROP && rx_d_rdy) begin
                drop_cnt <= drop_cnt - 8'd1;
            end

            // Completion comes after release so a new frame always wins the edge.
            if (ccw_ack && ccw_rdy) begin
                ccw_rdy <= 1'b0;
                ccw_len <= 8'd0;
            end
            if (done) begin
                ccw_rdy <= 1'b1;
                ccw_len <= len_r;
            end
        end
    end

    // NOTE: the payload buffer carries no reset; its contents are masked by ccw_len.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx[AW-1:0]] <= rx_d;
    end

    assign rd_data = (rd_addr < ccw_len) ? mem[rd_addr[AW-1:0]] : 8'h00;
    assign rx_busy = (state != CCWR_STATE_IDLE);

endmodule

// File: tb/tb_ccw_rcv.sv
// Directed bench for ccw_rcv: frames, handshake, length/overrun/timeout errors, reset mid-frame.
module tb_ccw_rcv;

    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic       rx_d_rdy = 1'b0;
    logic       ccw_rdy;
    logic [7:0] ccw_len;
    logic [7:0] rd_addr = 8'h00;
    logic [7:0] rd_data;
    logic       ccw_ack = 1'b0;
    logic       rx_busy;
    logic       err_len;
    logic       err_timeout;
    logic       err_overrun;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    ccw_rcv #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .rx_d        (rx_d),
        .rx_d_rdy    (rx_d_rdy),
        .ccw_rdy     (ccw_rdy),
        .ccw_len     (ccw_len),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .ccw_ack     (ccw_ack),
        .rx_busy     (rx_busy),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_overrun (err_overrun),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_d     = b;
        rx_d_rdy = 1'b1;
        tick();
        rx_d_rdy = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        rd_addr = addr;
        #1;
        check(tag, rd_data, exp);
    endtask

    task automatic ack();
        ccw_ack = 1'b1;
        tick();
        ccw_ack = 1'b0;
    endtask

    initial begin
        // 1: reset, slow N=3 frame
        idle(2);
        n_rst = 1'b1;
        check("rst_rdy", ccw_rdy, 8'd0);
        check("rst_len", ccw_len, 8'd0);
        check("rst_cnt", err_cnt, 8'd0);
        check("rst_busy", rx_busy, 8'd0);
        read_chk("rst_rd", 8'd0, 8'h00);
        send_byte(8'd3);
        idle(3);
        send_byte(8'h00);
        idle(3);
        send_byte(8'h01);
        idle(3);
        check("t1_rdy_early", ccw_rdy, 8'd0);
        send_byte(8'h02);
        check("t1_rdy", ccw_rdy, 8'd1);
        check("t1_len", ccw_len, 8'd3);
        read_chk("t1_rd0", 8'd0, 8'h00);
        read_chk("t1_rd1", 8'd1, 8'h01);
        read_chk("t1_rd2", 8'd2, 8'h02);
        read_chk("t1_rd3", 8'd3, 8'h00);

        // 2: ack, then full-length frame
        ack();
        check("t2_ack_rdy", ccw_rdy, 8'd0);
        check("t2_ack_len", ccw_len, 8'd0);
        send_byte(8'd16);
        for (int i = 0; i < 16; i++) send_byte(8'h10 + 8'(i * 3));
        check("t2_rdy", ccw_rdy, 8'd1);
        check("t2_len", ccw_len, 8'd16);
        for (int i = 0; i < 16; i++) read_chk("t2_rd", 8'(i), 8'h10 + 8'(i * 3));
        read_chk("t2_rd16", 8'd16, 8'h00);
        ack();

        // 3: illegal lengths, then a good frame
        send_byte(8'd0);
        check("t3_len0_pulse", err_len, 8'd1);
        check("t3_len0_cnt", err_cnt, 8'd1);
        check("t3_len0_busy", rx_busy, 8'd0);
        tick();
        check("t3_pulse_end", err_len, 8'd0);
        send_byte(8'd17);
        check("t3_len17_pulse", err_len, 8'd1);
        check("t3_len17_cnt", err_cnt, 8'd2);
        check("t3_len17_busy", rx_busy, 8'd0);
        send_byte(8'd2);
        send_byte(8'h5A);
        send_byte(8'hA5);
        check("t3_rdy", ccw_rdy, 8'd1);
        check("t3_len", ccw_len, 8'd2);
        read_chk("t3_rd0", 8'd0, 8'h5A);
        read_chk("t3_rd1", 8'd1, 8'hA5);

        // 4: overrun while the buffer is held
        send_byte(8'd2);
        check("t4_ovr_pulse", err_overrun, 8'd1);
        check("t4_ovr_cnt", err_cnt, 8'd3);
        check("t4_busy0", rx_busy, 8'd1);
        send_byte(8'hAA);
        check("t4_ovr_end", err_overrun, 8'd0);
        check("t4_busy1", rx_busy, 8'd1);
        send_byte(8'hBB);
        check("t4_busy2", rx_busy, 8'd0);
        check("t4_rdy", ccw_rdy, 8'd1);
        check("t4_len", ccw_len, 8'd2);
        read_chk("t4_rd0", 8'd0, 8'h5A);
        read_chk("t4_rd1", 8'd1, 8'hA5);
        ack();
        send_byte(8'd1);
        send_byte(8'hCC);
        check("t4_new_len", ccw_len, 8'd1);
        read_chk("t4_new_rd0", 8'd0, 8'hCC);
        ack();

        // 5: keep-alive strobe at TIMEOUT-1, then a real timeout
        send_byte(8'd4);
        send_byte(8'h11);
        idle(TIMEOUT - 1);
        send_byte(8'h22);
        check("t5_alive_to", err_timeout, 8'd0);
        check("t5_alive_busy", rx_busy, 8'd1);
        idle(TIMEOUT - 1);
        check("t5_pre_to", err_timeout, 8'd0);
        check("t5_pre_busy", rx_busy, 8'd1);
        tick();
        check("t5_to_pulse", err_timeout, 8'd1);
        check("t5_to_busy", rx_busy, 8'd0);
        check("t5_to_rdy", ccw_rdy, 8'd0);
        check("t5_to_cnt", err_cnt, 8'd4);
        tick();
        check("t5_to_end", err_timeout, 8'd0);
        send_byte(8'd1);
        send_byte(8'h77);
        check("t5_after_rdy", ccw_rdy, 8'd1);
        read_chk("t5_after_rd0", 8'd0, 8'h77);
        ack();

        // 6: reset in the middle of a frame
        send_byte(8'd3);
        send_byte(8'h44);
        check("t6_busy", rx_busy, 8'd1);
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        check("t6_rdy", ccw_rdy, 8'd0);
        check("t6_len", ccw_len, 8'd0);
        check("t6_busy_rst", rx_busy, 8'd0);
        check("t6_cnt", err_cnt, 8'd0);
        check("t6_errs", {5'd0, err_len, err_timeout, err_overrun}, 8'd0);
        read_chk("t6_rd", 8'd0, 8'h00);
        send_byte(8'd1);
        send_byte(8'h99);
        check("t6_new_rdy", ccw_rdy, 8'd1);
        check("t6_new_len", ccw_len, 8'd1);
        read_chk("t6_new_rd0", 8'd0, 8'h99);
        check("t6_new_cnt", err_cnt, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
